riscv_if_parcel_queue: RTL and testbench

Instruction-fetch parcel queue between the instruction memory bus and the core's instruction fetch port (`if_nxt_pc` / `if_parcel*`). It issues in-order pipelined fetch requests for the PC supplied by the core and buffers returned parcels in a DEPTH-entry FIFO. It presents the FIFO head to the core's IF stage and discards in-flight responses after `if_flush`.

---
 rtl/riscv_if_pkg.sv | 20 ++
 rtl/riscv_if_parcel_queue_if.sv | 41 ++++
 rtl/riscv_parcel_fifo.sv | 52 +++++
 rtl/riscv_if_parcel_queue.sv | 96 +++++++++
 tb/tb_riscv_if_parcel_queue.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_if_pkg.sv
// Shared instruction-fetch types: the parcel entry carried from the memory
// response path to the IF stage. The BIU-side fetch logic reuses it as well.
package riscv_if_pkg;

  localparam int unsigned IF_XLEN        = 32;
  localparam int unsigned IF_PARCEL_SIZE = 32;

  typedef struct packed {
    logic [IF_PARCEL_SIZE-1:0] parcel;
    logic [IF_XLEN-1:0]        pc;
    logic                      misaligned;
    logic                      page_fault;
  } if_parcel_entry_t;

  // Occupancy counters need one extra bit so that "full" (== depth) is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/riscv_if_parcel_queue_if.sv
// Fetch-side bundle: the core's next-PC/parcel port plus the instruction memory bus.
// Handshakes: imem_req is taken by memory in the cycle it is high; imem_ack returns
// responses in request order. A parcel is consumed when if_parcel_valid is set and
// if_stall/if_flush are low; if_stall_nxt_pc high means if_nxt_pc was not taken.
interface riscv_if_parcel_queue_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PARCEL_SIZE = 32
);
  logic [XLEN-1:0]          if_nxt_pc;
  logic                     if_stall_nxt_pc;
  logic                     if_stall;
  logic                     if_flush;
  logic [PARCEL_SIZE-1:0]   if_parcel;
  logic [XLEN-1:0]          if_parcel_pc;
  logic [PARCEL_SIZE/16-1:0] if_parcel_valid;
  logic                     if_parcel_misaligned;
  logic                     if_parcel_page_fault;
  logic                     imem_req;
  logic [XLEN-1:0]          imem_adr;
  logic                     imem_ack;
  logic [PARCEL_SIZE-1:0]   imem_q;
  logic                     imem_err;
  logic                     imem_misaligned;
  logic                     imem_page_fault;

  modport master (
    input  if_nxt_pc, if_stall, if_flush,
    input  imem_ack, imem_q, imem_err, imem_misaligned, imem_page_fault,
    output if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
    output if_parcel_misaligned, if_parcel_page_fault,
    output imem_req, imem_adr
  );

  modport slave (
    output if_nxt_pc, if_stall, if_flush,
    output imem_ack, imem_q, imem_err, imem_misaligned, imem_page_fault,
    input  if_stall_nxt_pc, if_parcel, if_parcel_pc, if_parcel_valid,
    input  if_parcel_misaligned, if_parcel_page_fault,
    input  imem_req, imem_adr
  );
endinterface

// File: rtl/riscv_parcel_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with clear. The head is read from
// registered storage, so it is stable for the whole cycle.
module riscv_parcel_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/riscv_if_parcel_queue.sv
// Instruction-fetch parcel queue: issues in-order fetches for the core's next PC,
// buffers responses and presents the head parcel to the IF stage.
module riscv_if_parcel_queue
  import riscv_if_pkg::*;
#(
  parameter int unsigned XLEN        = IF_XLEN,
  parameter int unsigned PARCEL_SIZE = IF_PARCEL_SIZE,
  parameter int unsigned DEPTH       = 4
) (
  input logic                    clk,
  input logic                    rstn,
  riscv_if_parcel_queue_if.master bus
);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PV = PARCEL_SIZE / 16;

  logic [CW-1:0]    count, pc_count;
  logic [CW-1:0]    pending_q, pending_d;
  logic [CW-1:0]    discard_q, discard_d;
  logic [CW:0]      inflight;
  logic             issue_ok, drop_ack, push, pop, head_valid;
  logic [XLEN-1:0]  pc_head;
  if_parcel_entry_t push_entry, head_entry;

  // Queued parcels plus outstanding requests must never exceed the FIFO, so every ack has a slot.
  assign inflight   = {1'b0, count} + {1'b0, pending_q};
  assign issue_ok   = rstn & ~bus.if_flush & (inflight < (CW+1)'(DEPTH));
  assign drop_ack   = bus.imem_ack & (bus.if_flush | (discard_q != '0));
  assign push       = bus.imem_ack & ~drop_ack;
  assign head_valid = rstn & (count != '0);
  assign pop        = head_valid & ~bus.if_stall & ~bus.if_flush;

  always_comb begin
    pending_d = pending_q + CW'(issue_ok) - CW'(bus.imem_ack);
    discard_d = discard_q;
    if (bus.if_flush) begin
      discard_d = pending_q - CW'(bus.imem_ack & ~issue_ok);
    end else if (bus.imem_ack && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pending_q <= '0;
      discard_q <= '0;
    end else begin
      pending_q <= pending_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) assert (pc_count == pending_q);
  end

  // Request PCs stay queued across a flush: their (discarded) acks still pop them.
  riscv_parcel_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .clear_i     (1'b0),
    .push_i      (issue_ok),
    .push_data_i (bus.if_nxt_pc),
    .pop_i       (bus.imem_ack),
    .head_o      (pc_head),
    .count_o     (pc_count)
  );

  always_comb begin
    push_entry.parcel     = bus.imem_q;
    push_entry.pc         = pc_head;
    push_entry.misaligned = bus.imem_misaligned;
    push_entry.page_fault = bus.imem_page_fault | bus.imem_err;
  end

  riscv_parcel_fifo #(.DEPTH(DEPTH), .WIDTH($bits(if_parcel_entry_t))) u_parcel_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .clear_i     (bus.if_flush),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .count_o     (count)
  );

  assign bus.imem_req             = issue_ok;
  assign bus.imem_adr             = bus.if_nxt_pc;
  assign bus.if_stall_nxt_pc      = ~issue_ok;
  assign bus.if_parcel            = head_entry.parcel;
  assign bus.if_parcel_pc         = head_entry.pc;
  assign bus.if_parcel_misaligned = head_entry.misaligned;
  assign bus.if_parcel_page_fault = head_entry.page_fault;
  assign bus.if_parcel_valid      = {PV{head_valid}};

endmodule

// File: tb/tb_riscv_if_parcel_queue.sv
// Bench for riscv_if_parcel_queue: in-order memory model with programmable latency,
// a core model that advances the PC on each accepted request, and a parcel scoreboard.
module tb_riscv_if_parcel_queue;
  localparam int XLEN  = 32;
  localparam int PS    = 32;
  localparam int DEPTH = 4;
  localparam int PV    = PS / 16;
  localparam int SBW   = XLEN + PS + 2;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [PS-1:0]   data;
    int              due;
    logic            err;
    logic            mis;
    logic            pf;
  } mem_req_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  riscv_if_parcel_queue_if #(.XLEN(XLEN), .PARCEL_SIZE(PS)) bus();

  riscv_if_parcel_queue #(.XLEN(XLEN), .PARCEL_SIZE(PS), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [SBW-1:0] exp_q[$];
  mem_req_t mem_q[$];
  int lat_min = 1;
  int lat_max = 1;
  int last_due = 0;
  logic adv = 1'b0;
  int issued = 0;
  int pops = 0;
  logic first_seen = 1'b0;
  logic [XLEN-1:0] first_pop_pc = '0;
  logic [XLEN-1:0] nxt_pc = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_pc(input logic [XLEN-1:0] pc);
    nxt_pc = pc;
    bus.if_nxt_pc = pc;
  endtask

  // Scoreboard and memory bookkeeping for the edge that is about to happen.
  task automatic observe();
    logic [SBW-1:0] got, e;
    mem_req_t m;
    int lat;
    adv = 1'b0;
    if (!rstn) begin
      exp_q.delete();
      mem_q.delete();
      last_due = 0;
      return;
    end
    check("valid_shape", 128'((bus.if_parcel_valid == '0) || (bus.if_parcel_valid == '1)), 1);
    if (bus.if_flush) begin
      exp_q.delete();
    end else if (bus.if_parcel_valid == '1 && !bus.if_stall) begin
      got = {bus.if_parcel_pc, bus.if_parcel, bus.if_parcel_misaligned, bus.if_parcel_page_fault};
      check("sb_nonempty", 128'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("parcel", 128'(got), 128'(e));
        if (e[SBW-1 -: XLEN] == 32'h208) check("err_pf", 128'(bus.if_parcel_page_fault), 1);
      end
      if (!first_seen) first_pop_pc = got[SBW-1 -: XLEN];
      first_seen = 1'b1;
      pops++;
    end
    if (bus.imem_req) begin
      check("imem_adr", 128'(bus.imem_adr), 128'(nxt_pc));
      lat = int'($urandom_range(lat_max, lat_min));
      m.pc   = nxt_pc;
      m.data = $urandom;
      m.err  = (nxt_pc == 32'h208);
      m.pf   = (nxt_pc[6:2] == 5'd13);
      m.mis  = (nxt_pc[6:2] == 5'd22);
      m.due  = cyc + lat;
      if (m.due <= last_due) m.due = last_due + 1;
      last_due = m.due;
      mem_q.push_back(m);
      exp_q.push_back({m.pc, m.data, m.mis, m.pf | m.err});
      adv = 1'b1;
      issued++;
    end
  endtask

  task automatic drive_mem();
    mem_req_t m;
    if (adv) set_pc(nxt_pc + 32'd4);
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      bus.imem_ack        = 1'b1;
      bus.imem_q          = m.data;
      bus.imem_err        = m.err;
      bus.imem_misaligned = m.mis;
      bus.imem_page_fault = m.pf;
    end else begin
      bus.imem_ack        = 1'b0;
      bus.imem_q          = '0;
      bus.imem_err        = 1'b0;
      bus.imem_misaligned = 1'b0;
      bus.imem_page_fault = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    cyc++;
    #1;
    drive_mem();
  endtask

  // Stall until the queue is full with nothing in flight, then pulse reset for one cycle.
  task automatic clean_restart(input logic [XLEN-1:0] pc);
    logic done;
    done = 1'b0;
    bus.if_stall = 1'b1;
    bus.if_flush = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      done = (mem_q.size() == 0) && !bus.imem_ack && !bus.imem_req;
    end
    check("fill_reached", 128'(done), 1);
    check("full_before_rst", 128'(bus.if_parcel_valid), 128'({PV{1'b1}}));
    rstn = 1'b0;
    #1;
    check("rst_req_low", 128'(bus.imem_req), 0);
    check("rst_stall_nxt", 128'(bus.if_stall_nxt_pc), 1);
    check("rst_valid_low", 128'(bus.if_parcel_valid), 0);
    tick();
    rstn = 1'b1;
    set_pc(pc);
    issued = 0;
    pops = 0;
    first_seen = 1'b0;
    #1;
    check("post_rst_valid", 128'(bus.if_parcel_valid), 0);
    check("post_rst_req", 128'(bus.imem_req), 1);
  endtask

  initial begin
    bus.if_stall = 1'b0;
    bus.if_flush = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_q = '0;
    bus.imem_err = 1'b0;
    bus.imem_misaligned = 1'b0;
    bus.imem_page_fault = 1'b0;
    set_pc(32'h200);
    rstn = 1'b0;
    tick();
    tick();
    check("reset_req", 128'(bus.imem_req), 0);
    check("reset_stall_nxt", 128'(bus.if_stall_nxt_pc), 1);
    check("reset_valid", 128'(bus.if_parcel_valid), 0);

    // Streaming at latency 1: no back-pressure on the PC, one parcel per cycle after fill.
    rstn = 1'b1;
    #1;
    check("first_req", 128'(bus.imem_req), 1);
    for (int i = 0; i < 30; i++) begin
      tick();
      check("no_stall_nxt", 128'(bus.if_stall_nxt_pc), 0);
      if (i >= 1) check("throughput", 128'(bus.if_parcel_valid), 128'({PV{1'b1}}));
    end

    // IF stall held: exactly DEPTH requests, then release drains in order.
    clean_restart(32'h600);
    for (int i = 0; i < 12; i++) tick();
    check("stall_issue_cnt", 128'(issued), DEPTH);
    check("stall_nxt_full", 128'(bus.if_stall_nxt_pc), 1);
    bus.if_stall = 1'b0;
    issued = 0;
    for (int i = 0; i < 10; i++) tick();
    check("release_pops", 128'(pops >= 4), 1);
    check("release_first_pc", 128'(first_pop_pc), 32'h600);
    check("issue_resumes", 128'(issued > 0), 1);

    // Flush with three requests outstanding: their acks must be dropped.
    clean_restart(32'h700);
    bus.if_stall = 1'b0;
    lat_min = 5;
    lat_max = 5;
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
        tick();
        hit = (mem_q.size() == 3) && !bus.imem_ack;
      end
      check("three_pending", 128'(hit), 1);
    end
    bus.if_flush = 1'b1;
    set_pc(32'h300);
    first_seen = 1'b0;
    pops = 0;
    #1;
    check("flush_no_req", 128'(bus.imem_req), 0);
    tick();
    bus.if_flush = 1'b0;
    check("flush3_empty", 128'(bus.if_parcel_valid), 0);
    for (int i = 0; i < 20; i++) tick();
    check("flush3_delivered", 128'(pops > 0), 1);
    check("flush3_first_pc", 128'(first_pop_pc), 32'h300);

    // Flush in the same cycle as an ack and a pop.
    lat_min = 2;
    lat_max = 2;
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 30 && !hit; i++) begin
        tick();
        hit = bus.imem_ack && (bus.if_parcel_valid == '1);
      end
      check("ack_pop_found", 128'(hit), 1);
    end
    bus.if_flush = 1'b1;
    set_pc(32'h400);
    first_seen = 1'b0;
    pops = 0;
    #1;
    check("flush_ack_no_req", 128'(bus.imem_req), 0);
    check("flush_ack_stall_nxt", 128'(bus.if_stall_nxt_pc), 1);
    tick();
    bus.if_flush = 1'b0;
    check("flush_ack_empty", 128'(bus.if_parcel_valid), 0);
    for (int i = 0; i < 20; i++) tick();
    check("flush_ack_first_pc", 128'(first_pop_pc), 32'h400);

    // Random latency, stalls and flushes.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      bus.if_stall = ($urandom_range(0, 3) == 0);
      bus.if_flush = ($urandom_range(0, 24) == 0);
      if (bus.if_flush) set_pc(32'h1000 + 32'(4 * $urandom_range(0, 63)));
      tick();
    end
    bus.if_flush = 1'b0;
    bus.if_stall = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
